// File: rtl/notch_biquad_sched_if.sv
// Stream and coefficient-configuration bundle for notch_biquad_sched.
// The slave modport is the filter's view; master is the host/source side.
interface notch_biquad_sched_if #(
    parameter int DW = 16,
    parameter int CW = 16
);
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          cfg_we;
    logic [2:0]    cfg_addr;
    logic [CW-1:0] cfg_wdata;
    logic          cfg_commit;
    logic          coef_pending;
    logic          busy;

    modport master (
        output s_valid, s_data, m_ready, cfg_we, cfg_addr, cfg_wdata, cfg_commit,
        input  s_ready, m_valid, m_data, coef_pending, busy
    );

    modport slave (
        input  s_valid, s_data, m_ready, cfg_we, cfg_addr, cfg_wdata, cfg_commit,
        output s_ready, m_valid, m_data, coef_pending, busy
    );
endinterface

// File: rtl/notch_biquad_sched.sv
// Direct Form I notch biquad sequenced over one shared MAC with an atomic coefficient bank.
// Optional saturation sticky flag (sat_sticky/sat_clr) enabled by defining NOTCH_SAT_FLAG_EN.
module notch_biquad_sched #(
    parameter int DW = 16,
    parameter int CW = 16
) (
    input  logic clk,
    input  logic rst_n,
`ifdef NOTCH_SAT_FLAG_EN
    output logic sat_sticky,
    input  logic sat_clr,
`endif
    notch_biquad_sched_if.slave bus
);
    localparam int AW = DW + CW + 3;
    localparam int PW = DW + CW;

    localparam logic signed [CW-1:0] COEF_ONE = {2'b01, {(CW-2){1'b0}}};
    localparam logic signed [AW-1:0] RND_BIAS = {{(AW-1){1'b0}}, 1'b1} << (CW-3);
    localparam logic signed [DW-1:0] SAT_MAX  = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] SAT_MIN  = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [AW-1:0] LIM_MAX  = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] LIM_MIN  = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE, MAC0, MAC1, MAC2, MAC3, MAC4, ROUND, OUT
    } state_t;

    state_t                 state;
    logic signed [AW-1:0]   acc;
    logic signed [DW-1:0]   x0, x1, x2, y1, y2;
    logic signed [CW-1:0]   active [5];
    logic signed [CW-1:0]   shadow [5];
    logic                   pending;
    logic                   m_valid_q;
    logic signed [DW-1:0]   m_data_q;

    logic signed [CW-1:0]   mac_coef;
    logic signed [DW-1:0]   mac_hist;
    logic                   mac_neg;
    logic signed [PW-1:0]   prod;
    logic signed [AW-1:0]   prod_ext;
    logic signed [AW-1:0]   acc_next;
    logic signed [AW-1:0]   rnd;
    logic signed [AW-1:0]   shifted;
    logic                   sat_hi;
    logic                   sat_lo;
    logic signed [DW-1:0]   y_sat;

    // Operand select for the shared multiplier; feedback terms are subtracted.
    always_comb begin
        mac_coef = '0;
        mac_hist = '0;
        mac_neg  = 1'b0;
        case (state)
            MAC0: begin mac_coef = active[0]; mac_hist = x0; end
            MAC1: begin mac_coef = active[1]; mac_hist = x1; end
            MAC2: begin mac_coef = active[2]; mac_hist = x2; end
            MAC3: begin mac_coef = active[3]; mac_hist = y1; mac_neg = 1'b1; end
            MAC4: begin mac_coef = active[4]; mac_hist = y2; mac_neg = 1'b1; end
            default: ;
        endcase
    end

    assign prod     = $signed({{DW{mac_coef[CW-1]}}, mac_coef} * {{CW{mac_hist[DW-1]}}, mac_hist});
    assign prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
    assign acc_next = mac_neg ? (acc - prod_ext) : (acc + prod_ext);

    assign rnd     = acc + RND_BIAS;
    assign shifted = rnd >>> (CW-2);
    assign sat_hi  = (shifted > LIM_MAX);
    assign sat_lo  = (shifted < LIM_MIN);
    assign y_sat   = sat_hi ? SAT_MAX : (sat_lo ? SAT_MIN : shifted[DW-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            x0        <= '0;
            x1        <= '0;
            x2        <= '0;
            y1        <= '0;
            y2        <= '0;
            pending   <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            for (int i = 0; i < 5; i++) begin
                active[i] <= (i == 0) ? COEF_ONE : '0;
                shadow[i] <= (i == 0) ? COEF_ONE : '0;
            end
        end else begin
            if (bus.cfg_we && (bus.cfg_addr <= 3'd4))
                shadow[bus.cfg_addr] <= bus.cfg_wdata;
            if (bus.cfg_commit)
                pending <= 1'b1;

            case (state)
                // The copy reads pre-edge shadow and blocks sample acceptance this cycle.
                IDLE: begin
                    if (pending) begin
                        for (int i = 0; i < 5; i++)
                            active[i] <= shadow[i];
                        pending <= 1'b0;
                    end else if (bus.s_valid) begin
                        x0    <= bus.s_data;
                        acc   <= '0;
                        state <= MAC0;
                    end
                end
                MAC0: begin acc <= acc_next; state <= MAC1;  end
                MAC1: begin acc <= acc_next; state <= MAC2;  end
                MAC2: begin acc <= acc_next; state <= MAC3;  end
                MAC3: begin acc <= acc_next; state <= MAC4;  end
                MAC4: begin acc <= acc_next; state <= ROUND; end
                ROUND: begin
                    m_data_q  <= y_sat;
                    m_valid_q <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (bus.m_ready) begin
                        x2        <= x1;
                        x1        <= x0;
                        y2        <= y1;
                        y1        <= m_data_q;
                        m_valid_q <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef NOTCH_SAT_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_sticky <= 1'b0;
        else if ((state == ROUND) && (sat_hi || sat_lo))
            sat_sticky <= 1'b1;
        else if (sat_clr)
            sat_sticky <= 1'b0;
    end
`endif

    assign bus.s_ready      = (state == IDLE) && !pending;
    assign bus.m_valid      = m_valid_q;
    assign bus.m_data       = m_data_q;
    assign bus.coef_pending = pending;
    assign bus.busy         = (state != IDLE);
endmodule
